// File: rtl/instruction_decode.sv
// RV32I ID stage: register file, operand/immediate decode, load-use hazard detection.
// Latency: one cycle from IF/ID to the ID/EX register; bubble is combinational.
// Backpressure: MA_stall holds ID/EX; bubble asks IF to hold IF/ID for one cycle.
module instruction_decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MA_stall,
  input  logic             br_taken,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             wb_load,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             bubble,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [31:0]      id_rs1_data,
  output logic [31:0]      id_rs2_data,
  output logic [31:0]      id_imm,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic        use_rs1;
  logic        use_rs2;
  logic        has_rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        hazard;

  assign opcode = instr_in[6:0];

  // Decode operand usage and the immediate format from the opcode.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    imm     = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        has_rd = 1'b1;
        imm    = {instr_in[31:12], 12'b0};
      end
      OP_JAL: begin
        has_rd = 1'b1;
        imm    = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        imm     = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        has_rd  = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
      end
    endcase
  end

  assign rs1_idx = use_rs1 ? instr_in[19:15] : 5'd0;
  assign rs2_idx = use_rs2 ? instr_in[24:20] : 5'd0;
  assign rd_idx  = has_rd  ? instr_in[11:7]  : 5'd0;

  // Register read with x0 hardwired and a bypass from the write happening this cycle.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != 5'd0) begin
      rs1_val = (wb_load && wb_rd == rs1_idx) ? wb_data : regs[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      rs2_val = (wb_load && wb_rd == rs2_idx) ? wb_data : regs[rs2_idx];
    end
  end

  // Unused source indices are already forced to 0, and id_rd is nonzero, so an
  // index match alone implies a real dependency.
  assign hazard = id_valid && (id_instr[6:0] == OP_LOAD) && (id_rd != 5'd0) &&
                  ((rs1_idx == id_rd) || (rs2_idx == id_rd));
  assign bubble = hazard && !br_taken;

  // Architectural register file; WB writes are never held by the memory stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_load && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX pipeline register: reset > stall hold > flush > bubble > capture.
  always_ff @(posedge clk) begin
    if (rst || (!MA_stall && (br_taken || bubble))) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
    end else if (!MA_stall) begin
      id_valid    <= 1'b1;
      id_pc       <= pc_in;
      id_instr    <= instr_in;
      id_rs1      <= rs1_idx;
      id_rs2      <= rs2_idx;
      id_rd       <= rd_idx;
      id_rs1_data <= rs1_val;
      id_rs2_data <= rs2_val;
      id_imm      <= imm;
    end
  end

  // Saturating count of cycles in which a bubble actually reaches ID/EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble && !MA_stall && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode table plus hazard/flush/stall/reset sequences.
// Stimulus is driven 1 ns after posedge; outputs sampled 1 ns after the next posedge.
// bubble_cnt is built 4 bits wide so saturation is reachable in a short run.
module tb_instruction_decode;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, MA_stall, br_taken, wb_load;
  logic [31:0]   pc_in, instr_in, wb_data;
  logic [4:0]    wb_rd;
  logic          bubble, id_valid;
  logic [31:0]   id_pc, id_instr, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [CW-1:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  instruction_decode #(.NOP_INSTR(32'h00000013), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .MA_stall(MA_stall), .br_taken(br_taken),
    .pc_in(pc_in), .instr_in(instr_in), .wb_load(wb_load), .wb_rd(wb_rd),
    .wb_data(wb_data), .bubble(bubble), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] LW_X3    = 32'h0000A183; // lw  x3,0(x1)
  localparam logic [31:0] ADD_X4   = 32'h00218233; // add x4,x3,x2
  localparam logic [31:0] LUI_X3   = 32'h000011B7; // lui x3,0x1
  localparam logic [31:0] LUI_X1   = 32'hABCDE0B7; // lui x1,0xABCDE
  localparam logic [31:0] ADD_X6   = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] ADD_X10  = 32'h00138533; // add x10,x7,x1

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        wbl;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string n, logic [31:0] ins, logic wl, logic [4:0] wr,
                              logic [31:0] wd, logic [4:0] r1, logic [4:0] r2,
                              logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] im);
    vec_t v;
    v.name = n; v.instr = ins; v.wbl = wl; v.wrd = wr; v.wdat = wd;
    v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.d1 = d1; v.d2 = d2; v.imm = im;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] ins, logic [31:0] pc);
    instr_in = ins;
    pc_in    = pc;
    wb_load  = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
  endtask

  task automatic check_nop(string tag);
    check({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
    check({tag, "_instr"}, id_instr, NOP);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_rd"}, {27'b0, id_rd}, 32'd0);
    check({tag, "_rs1d"}, id_rs1_data, 32'd0);
    check({tag, "_imm"}, id_imm, 32'd0);
  endtask

  // One load-use pair: load in ID/EX, dependent stalls one cycle, then captured.
  task automatic load_use_pair();
    drive(LW_X3, 32'h200); step();
    drive(ADD_X4, 32'h204); step();
    step();
  endtask

  initial begin
    vecs[0]  = mk("nop_wb_x5",   NOP,          1, 5, 32'hDEADBEEF, 0, 0, 0,  32'h0,        32'h0,  32'h0);
    vecs[1]  = mk("add_x6",      ADD_X6,       0, 0, 32'h0,        5, 0, 6,  32'hDEADBEEF, 32'h0,  32'h0);
    vecs[2]  = mk("addi_bypass", 32'hFFF38413, 1, 7, 32'h12345678, 7, 0, 8,  32'h12345678, 32'h0,  32'hFFFFFFFF);
    vecs[3]  = mk("addi_x0",     32'h00500493, 1, 0, 32'h0000FFFF, 0, 0, 9,  32'h0,        32'h0,  32'h00000005);
    vecs[4]  = mk("sw",          32'hFE20AE23, 1, 1, 32'h00000100, 1, 2, 0,  32'h100,      32'h0,  32'hFFFFFFFC);
    vecs[5]  = mk("beq",         32'hFE208CE3, 1, 2, 32'h00000055, 1, 2, 0,  32'h100,      32'h55, 32'hFFFFFFF8);
    vecs[6]  = mk("lui",         LUI_X1,       0, 0, 32'h0,        0, 0, 1,  32'h0,        32'h0,  32'hABCDE000);
    vecs[7]  = mk("jal",         32'h001000EF, 0, 0, 32'h0,        0, 0, 1,  32'h0,        32'h0,  32'h00000800);
    vecs[8]  = mk("unknown",     32'hFFFFFFFF, 0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0,  32'h0);
    vecs[9]  = mk("add_x10",     ADD_X10,      0, 0, 32'h0,        7, 1, 10, 32'h12345678, 32'h100, 32'h0);
    vecs[10] = mk("x0_unwritten", ADD_X6,      0, 0, 32'h0,        5, 0, 6,  32'hDEADBEEF, 32'h0,  32'h0);

    rst = 1'b1; MA_stall = 1'b0; br_taken = 1'b0;
    drive(NOP, 32'h0);
    step(); step();
    check_nop("reset");
    check("reset_cnt", {28'b0, bubble_cnt}, 32'd0);
    check("reset_bubble", {31'b0, bubble}, 32'd0);
    rst = 1'b0;

    // Single-cycle decode table.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].instr, 32'h100 + 32'(4 * i));
      wb_load = vecs[i].wbl; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdat;
      #1;
      check({vecs[i].name, "_bubble"}, {31'b0, bubble}, 32'd0);
      step();
      check({vecs[i].name, "_valid"}, {31'b0, id_valid}, 32'd1);
      check({vecs[i].name, "_pc"},    id_pc, 32'h100 + 32'(4 * i));
      check({vecs[i].name, "_instr"}, id_instr, vecs[i].instr);
      check({vecs[i].name, "_rs1"},   {27'b0, id_rs1}, {27'b0, vecs[i].rs1});
      check({vecs[i].name, "_rs2"},   {27'b0, id_rs2}, {27'b0, vecs[i].rs2});
      check({vecs[i].name, "_rd"},    {27'b0, id_rd},  {27'b0, vecs[i].rd});
      check({vecs[i].name, "_rs1d"},  id_rs1_data, vecs[i].d1);
      check({vecs[i].name, "_rs2d"},  id_rs2_data, vecs[i].d2);
      check({vecs[i].name, "_imm"},   id_imm, vecs[i].imm);
    end

    // Load-use: exactly one bubble, then the dependent instruction is captured.
    drive(LW_X3, 32'h200); step();
    drive(ADD_X4, 32'h204); #1;
    check("lu_bubble", {31'b0, bubble}, 32'd1);
    step();
    check_nop("lu_nop");
    check("lu_cnt", {28'b0, bubble_cnt}, 32'd1);
    check("lu_rebubble", {31'b0, bubble}, 32'd0);
    step();
    check("lu_add_valid", {31'b0, id_valid}, 32'd1);
    check("lu_add_rd", {27'b0, id_rd}, 32'd4);
    check("lu_add_rs1", {27'b0, id_rs1}, 32'd3);
    check("lu_add_rs2d", id_rs2_data, 32'h55);

    // Load followed by an instruction without sources: no bubble.
    drive(LW_X3, 32'h210); step();
    drive(LUI_X3, 32'h214); #1;
    check("nodep_bubble", {31'b0, bubble}, 32'd0);
    step();
    check("nodep_valid", {31'b0, id_valid}, 32'd1);
    check("nodep_rd", {27'b0, id_rd}, 32'd3);
    check("nodep_cnt", {28'b0, bubble_cnt}, 32'd1);

    // Branch redirect suppresses the bubble and flushes ID/EX.
    drive(LW_X3, 32'h220); step();
    drive(ADD_X4, 32'h224); br_taken = 1'b1; #1;
    check("flush_bubble", {31'b0, bubble}, 32'd0);
    step();
    check_nop("flush");
    check("flush_cnt", {28'b0, bubble_cnt}, 32'd1);
    br_taken = 1'b0;

    // Stall with a pending redirect: hold for 3 cycles, flush on release.
    drive(LUI_X1, 32'h230); step();
    MA_stall = 1'b1; br_taken = 1'b1;
    drive(ADD_X10, 32'h234);
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_valid", {31'b0, id_valid}, 32'd1);
      check("stall_instr", id_instr, LUI_X1);
      check("stall_pc", id_pc, 32'h230);
      check("stall_imm", id_imm, 32'hABCDE000);
    end
    MA_stall = 1'b0;
    step();
    check_nop("release_flush");
    br_taken = 1'b0;

    // Reset during a stall with a held load-use hazard.
    drive(LW_X3, 32'h240); step();
    MA_stall = 1'b1;
    drive(ADD_X4, 32'h244); #1;
    check("held_bubble", {31'b0, bubble}, 32'd1);
    step(); step();
    check("held_instr", id_instr, LW_X3);
    check("held_cnt", {28'b0, bubble_cnt}, 32'd1);
    rst = 1'b1;
    step();
    check_nop("midstall_rst");
    check("midstall_rst_cnt", {28'b0, bubble_cnt}, 32'd0);
    check("midstall_rst_bubble", {31'b0, bubble}, 32'd0);
    rst = 1'b0; MA_stall = 1'b0;
    drive(ADD_X10, 32'h250); step();
    check("cleared_x7", id_rs1_data, 32'd0);
    check("cleared_x1", id_rs2_data, 32'd0);

    // Counter saturation: 17 bubbles into a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      load_use_pair();
      if (k == 13) check("cnt_14", {28'b0, bubble_cnt}, 32'd14);
    end
    check("cnt_sat", {28'b0, bubble_cnt}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
RV32I pipeline ID stage, directly downstream of instruction fetch.
- Consumes the IF/ID pair (PC, instruction word).
- Owns the 32x32 architectural register file, written from WB.
- Generates immediates and detects load-use hazards, driving `bubble` back to IF.
- Registers decoded operands into the ID/EX pipeline register.

Parameters:
NOP_INSTR, 32'h00000013, instruction word inserted into ID/EX on flush, bubble or reset
CNT_W, 16, width of the saturating bubble-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
MA_stall  in  1  memory-stage stall; holds ID/EX
br_taken  in  1  EX branch/jump redirect; flushes ID/EX
pc_in  in  32  PC from IF/ID
instr_in  in  32  instruction from IF/ID
wb_load  in  1  register-file write enable from WB
wb_rd  in  5  WB destination register
wb_data  in  32  WB write data
bubble  out  1  load-use stall request to IF (combinational)
id_valid  out  1  ID/EX holds a real instruction
id_pc  out  32  ID/EX PC
id_instr  out  32  ID/EX instruction word
id_rs1  out  5  ID/EX rs1 index (0 if unused)
id_rs2  out  5  ID/EX rs2 index (0 if unused)
id_rd  out  5  ID/EX rd index (0 if none)
id_rs1_data  out  32  ID/EX rs1 value
id_rs2_data  out  32  ID/EX rs2 value
id_imm  out  32  ID/EX sign-extended immediate
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
Reset and clocking:
- Reset rst is synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset state: all 32 registers = 0; id_valid=0; id_instr=NOP_INSTR; every other ID/EX field = 0; bubble_cnt=0.

Register file:
- x0 reads 0 and is never written.
- Write occurs when wb_load && wb_rd!=0, independent of MA_stall.
- Same-cycle bypass: if wb_load && wb_rd==rsN && rsN!=0, rsN data = wb_data.

Operand use by opcode:
- rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- rs2 used by BRANCH, STORE, OP.
- LUI, AUIPC, JAL use neither operand.
- Unused rs fields are forced to 0 in ID/EX.
- rd is forced to 0 for BRANCH, STORE and unknown opcodes.

Immediates:
- I: LOAD, OP-IMM, JALR.
- S: STORE.
- B: BRANCH.
- U: LUI, AUIPC.
- J: JAL.
- All immediates sign-extended per RV32I. Unknown opcode -> imm 0.

Hazard detection:
- hazard = id_valid && id_instr is LOAD (opcode 7'b0000011) && id_rd!=0 && (id_rd matches a used rs1 or rs2 of instr_in).
- bubble = hazard && !br_taken (combinational, no latency).

ID/EX update priority:
1. rst: reset state.
2. MA_stall: hold all fields.
3. br_taken: load NOP (id_valid=0, id_instr=NOP_INSTR, other fields 0).
4. bubble: load NOP.
5. Otherwise: capture decoded instr_in/pc_in with id_valid=1.

Boundary rules:
- br_taken during MA_stall is ignored by ID. EX/MEM holds br_taken asserted until the stall releases.
- IF holds IF/ID while bubble=1, so the dependent instruction is re-decoded the next cycle. That decode sees the NOP in ID/EX and proceeds, giving exactly one bubble cycle per load-use hazard.
- bubble_cnt increments on each cycle where bubble && !MA_stall, and saturates at all-ones.
- Reset mid-stall discards all held state.

Test Plan:
1. Reset, then write x5=0xDEADBEEF via WB, then decode `add x6,x5,x0` -> next cycle id_rs1_data=0xDEADBEEF, id_rs2_data=0, id_rd=6, id_valid=1.
2. Same-cycle bypass: wb_load=1, wb_rd=7, wb_data=0x12345678 while decoding `addi x8,x7,-1` -> id_rs1_data=0x12345678, id_imm=0xFFFFFFFF. Repeat with wb_rd=0 on x0 -> x0 reads 0.
3. Immediates:
   - `sw x2,-4(x1)` -> id_imm=0xFFFFFFFC, id_rd=0.
   - `beq` with offset -8 -> id_imm=0xFFFFFFF8.
   - `lui x1,0xABCDE` -> id_imm=0xABCDE000, id_rs1=0.
   - `jal` offset +2048 -> id_imm=0x00000800.
4. Load-use: `lw x3,0(x1)` followed by `add x4,x3,x2` -> bubble=1 for exactly one cycle, ID/EX then NOP (id_valid=0), then the add captured. bubble_cnt increments by 1. Repeating with `lui x3` as the second instruction -> bubble stays 0.
5. Flush and stall:
   - br_taken=1 -> next cycle id_valid=0, id_instr=0x00000013, bubble forced 0 despite a load-use match.
   - MA_stall=1 for 3 cycles with br_taken=1 -> ID/EX unchanged throughout. Flush occurs on the first cycle with MA_stall=0.
6. Assert rst during MA_stall with a held hazard -> next cycle all outputs at reset values, registers read 0, bubble_cnt=0.
